// File: rtl/decode_stage_pkg.sv
// Shared types and constants for the decode stage of the 16-bit MIPS-style core.
// Optional stall counter is enabled with DECODE_STALL_CNT_EN (see decode_stage).
package decode_stage_pkg;

    localparam logic [4:0]  HALT_OPCODE = 5'b00000;
    localparam logic [4:0]  NOP_OPCODE  = 5'b00001;
    localparam logic [15:0] NOP_INSTR   = {NOP_OPCODE, 11'b0};
    localparam int          NUM_REGS    = 8;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 11;
    localparam int RS_MSB = 10;
    localparam int RS_LSB = 8;
    localparam int RT_MSB = 7;
    localparam int RT_LSB = 5;

    typedef logic [2:0] reg_idx_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_next;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/decode_stage_regfile_bypass.sv
// 8x16 register file: one synchronous write port, two async read ports
// with same-cycle write-back bypass. No hardwired zero register.
module decode_stage_regfile_bypass
    import decode_stage_pkg::*;
#(
    parameter int DEPTH = NUM_REGS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en,
    input  reg_idx_t    wb_reg,
    input  logic [15:0] wb_data,
    input  reg_idx_t    rs_idx,
    input  reg_idx_t    rt_idx,
    output logic [15:0] rs_data,
    output logic [15:0] rt_data
);

    logic [15:0] regs_q [DEPTH];
    logic [15:0] regs_d [DEPTH];

    always_comb begin
        regs_d = regs_q;
        if (wb_en) regs_d[wb_reg] = wb_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) regs_q <= '{default: '0};
        else     regs_q <= regs_d;
    end

    assign rs_data = (wb_en && wb_reg == rs_idx) ? wb_data : regs_q[rs_idx];
    assign rt_data = (wb_en && wb_reg == rt_idx) ? wb_data : regs_q[rt_idx];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: IF/ID register, load-use hazard, sticky halt, register file.
// Define DECODE_STALL_CNT_EN to build the saturating stall_count counter.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr_in,
    input  logic [15:0] pc_next_in,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [2:0]  wb_reg,
    input  logic [15:0] wb_data,
    input  logic        ex_memread,
    input  logic [2:0]  ex_rd,
    output logic        stall,
    output logic        valid_out,
    output logic [15:0] instr_out,
    output logic [15:0] pc_next_out,
    output logic [2:0]  rs_idx,
    output logic [2:0]  rt_idx,
    output logic [15:0] rs_data,
    output logic [15:0] rt_data,
    output logic [15:0] imm5_sext,
    output logic [15:0] imm8_sext,
    output logic [15:0] disp11_sext,
    output logic        halt,
    output logic [15:0] stall_count
);

    if_id_t ifid_q, ifid_d;
    logic   halted_q, halted_d;
    logic   hazard;

    assign instr_out   = ifid_q.instr;
    assign pc_next_out = ifid_q.pc_next;
    assign valid_out   = ifid_q.valid;

    assign rs_idx = instr_out[RS_MSB:RS_LSB];
    assign rt_idx = instr_out[RT_MSB:RT_LSB];

    // Both fields compared regardless of opcode: conservative on purpose.
    assign hazard = valid_out & ex_memread
                  & (ex_rd == rs_idx | ex_rd == rt_idx);
    assign stall  = hazard | halted_q;
    assign halt   = valid_out & (instr_out[OP_MSB:OP_LSB] == HALT_OPCODE);

    always_comb begin
        ifid_d = ifid_q;
        if (flush) begin
            ifid_d = '{instr: NOP_INSTR, pc_next: 16'h0000, valid: 1'b0};
        end else if (!stall) begin
            ifid_d = '{instr: instr_in, pc_next: pc_next_in, valid: 1'b1};
        end
    end

    // A flush in the halt cycle kills the HALT before it can stick.
    assign halted_d = halted_q | (halt & ~flush);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_q   <= '{instr: NOP_INSTR, pc_next: 16'h0000, valid: 1'b0};
            halted_q <= 1'b0;
        end else begin
            ifid_q   <= ifid_d;
            halted_q <= halted_d;
        end
    end

    decode_stage_regfile_bypass u_regfile_bypass (
        .clk     (clk),
        .rst     (rst),
        .wb_en   (wb_en),
        .wb_reg  (wb_reg),
        .wb_data (wb_data),
        .rs_idx  (rs_idx),
        .rt_idx  (rt_idx),
        .rs_data (rs_data),
        .rt_data (rt_data)
    );

    assign imm5_sext   = {{11{instr_out[4]}},  instr_out[4:0]};
    assign imm8_sext   = {{8{instr_out[7]}},   instr_out[7:0]};
    assign disp11_sext = {{5{instr_out[10]}},  instr_out[10:0]};

`ifdef DECODE_STALL_CNT_EN
    logic [15:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && !halted_q && stall_count_q != 16'hFFFF)
            stall_count_d = stall_count_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_count_q <= 16'h0000;
        else     stall_count_q <= stall_count_d;
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Randomized + directed bench for decode_stage against a behavioural model.
// Counter checks follow DECODE_STALL_CNT_EN.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr_in, pc_next_in, wb_data;
    logic        flush, wb_en, ex_memread;
    logic [2:0]  wb_reg, ex_rd;
    logic        stall, valid_out, halt;
    logic [15:0] instr_out, pc_next_out, rs_data, rt_data;
    logic [2:0]  rs_idx, rt_idx;
    logic [15:0] imm5_sext, imm8_sext, disp11_sext, stall_count;

    int errors = 0;
    int checks = 0;

    // Reference state
    logic [15:0] m_instr, m_pc, m_cnt;
    logic        m_valid, m_halted;
    logic [15:0] m_regs [8];

    always #5 clk = ~clk;

    decode_stage dut (
        .clk         (clk),
        .rst         (rst),
        .instr_in    (instr_in),
        .pc_next_in  (pc_next_in),
        .flush       (flush),
        .wb_en       (wb_en),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .ex_memread  (ex_memread),
        .ex_rd       (ex_rd),
        .stall       (stall),
        .valid_out   (valid_out),
        .instr_out   (instr_out),
        .pc_next_out (pc_next_out),
        .rs_idx      (rs_idx),
        .rt_idx      (rt_idx),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .imm5_sext   (imm5_sext),
        .imm8_sext   (imm8_sext),
        .disp11_sext (disp11_sext),
        .halt        (halt),
        .stall_count (stall_count)
    );

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_instr  = 16'h0800;
        m_pc     = 16'h0000;
        m_valid  = 1'b0;
        m_halted = 1'b0;
        m_cnt    = 16'h0000;
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    endtask

    function automatic logic exp_stall();
        logic [2:0] rs, rt;
        rs = m_instr[10:8];
        rt = m_instr[7:5];
        return m_halted
            || (m_valid && ex_memread && (ex_rd == rs || ex_rd == rt));
    endfunction

    function automatic logic [15:0] exp_read(input logic [2:0] idx);
        if (wb_en && wb_reg == idx) return wb_data;
        return m_regs[idx];
    endfunction

    function automatic logic [15:0] sext(input logic [15:0] v, input int w);
        logic [15:0] r;
        r = v;
        for (int i = w; i < 16; i++) r[i] = v[w-1];
        return r;
    endfunction

    task automatic check_outputs();
        chk("stall", {15'b0, stall}, {15'b0, exp_stall()});
        chk("valid", {15'b0, valid_out}, {15'b0, m_valid});
        chk("instr", instr_out, m_instr);
        chk("pc_next", pc_next_out, m_pc);
        chk("rs_idx", {13'b0, rs_idx}, {13'b0, m_instr[10:8]});
        chk("rt_idx", {13'b0, rt_idx}, {13'b0, m_instr[7:5]});
        chk("rs_data", rs_data, exp_read(m_instr[10:8]));
        chk("rt_data", rt_data, exp_read(m_instr[7:5]));
        chk("imm5", imm5_sext, sext(m_instr & 16'h001F, 5));
        chk("imm8", imm8_sext, sext(m_instr & 16'h00FF, 8));
        chk("disp11", disp11_sext, sext(m_instr & 16'h07FF, 11));
        chk("halt", {15'b0, halt},
            {15'b0, m_valid && m_instr[15:11] == 5'd0});
        chk("stall_count", stall_count, m_cnt);
    endtask

    // Called from a negedge with inputs already driven.
    task automatic step();
        logic        s, h;
        logic [15:0] n_instr, n_pc, n_cnt;
        logic        n_valid;
        #1;
        check_outputs();
        s = exp_stall();
        h = m_valid && m_instr[15:11] == 5'd0;
        n_instr = m_instr;
        n_pc    = m_pc;
        n_valid = m_valid;
        if (flush) begin
            n_instr = 16'h0800;
            n_pc    = 16'h0000;
            n_valid = 1'b0;
        end else if (!(s || m_halted)) begin
            n_instr = instr_in;
            n_pc    = pc_next_in;
            n_valid = 1'b1;
        end
        n_cnt = m_cnt;
`ifdef DECODE_STALL_CNT_EN
        if (s && !m_halted && m_cnt != 16'hFFFF) n_cnt = m_cnt + 16'd1;
`endif
        @(posedge clk);
        if (wb_en) m_regs[wb_reg] = wb_data;
        m_instr  = n_instr;
        m_pc     = n_pc;
        m_valid  = n_valid;
        m_halted = m_halted || (h && !flush);
        m_cnt    = n_cnt;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush      = 1'b0;
        wb_en      = 1'b0;
        wb_reg     = 3'd0;
        wb_data    = 16'h0000;
        ex_memread = 1'b0;
        ex_rd      = 3'd0;
    endtask

    // Asserted away from a clock edge; checks the immediate clear.
    task automatic mid_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_stall", {15'b0, stall}, 16'h0000);
        chk("rst_instr", instr_out, 16'h0800);
        chk("rst_valid", {15'b0, valid_out}, 16'h0000);
        chk("rst_cnt", stall_count, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        instr_in   = 16'h0000;
        pc_next_in = 16'h0000;
        idle_inputs();
        model_reset();
        #2;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;

        // Basic capture
        instr_in = 16'h4123; pc_next_in = 16'h0002;
        step();
        chk("cap_instr", instr_out, 16'h4123);
        chk("cap_rs", {13'b0, rs_idx}, 16'd1);

        // Write r3, then bypass a second write in the same cycle as read
        instr_in = 16'h4360; pc_next_in = 16'h0004;
        wb_en = 1'b1; wb_reg = 3'd3; wb_data = 16'hBEEF;
        step();
        wb_data = 16'h1234;
        #1;
        chk("bypass", rs_data, 16'h1234);
        step();
        idle_inputs();
        #1;
        chk("after_wb", rs_data, 16'h1234);
        step();

        // Load-use on rs=2
        instr_in = 16'h4200; pc_next_in = 16'h0010;
        step();
        instr_in = 16'h5AA1; pc_next_in = 16'h0012;
        ex_memread = 1'b1; ex_rd = 3'd2;
        #1;
        chk("lu_stall", {15'b0, stall}, 16'd1);
        step();
        chk("lu_hold", instr_out, 16'h4200);
        ex_memread = 1'b0;
        step();
        chk("lu_cap", instr_out, 16'h5AA1);

        // Flush beats stall
        instr_in = 16'h4200;
        step();
        ex_memread = 1'b1; ex_rd = 3'd2; flush = 1'b1;
        step();
        idle_inputs();
        chk("fl_instr", instr_out, 16'h0800);
        chk("fl_valid", {15'b0, valid_out}, 16'd0);
        chk("fl_stall", {15'b0, stall}, 16'd0);

        // Random traffic, HALT opcode excluded
        for (int i = 0; i < 400; i++) begin
            instr_in   = 16'($urandom);
            if (instr_in[15:11] == 5'd0) instr_in[11] = 1'b1;
            pc_next_in = 16'($urandom);
            flush      = ($urandom_range(0, 9) == 0);
            wb_en      = ($urandom_range(0, 1) == 1);
            wb_reg     = 3'($urandom);
            wb_data    = 16'($urandom);
            ex_memread = ($urandom_range(0, 3) == 0);
            ex_rd      = 3'($urandom);
            step();
        end
        idle_inputs();

        // HALT, then freeze
        instr_in = 16'h0000;
        step();
        chk("halt_seen", {15'b0, halt}, 16'd1);
        instr_in = 16'h6666;
        step();
        for (int i = 0; i < 5; i++) begin
            instr_in = 16'($urandom) | 16'h0800;
            step();
        end
        chk("halt_stall", {15'b0, stall}, 16'd1);
        mid_reset();
        step();

`ifdef DECODE_STALL_CNT_EN
        mid_reset();
        for (int k = 0; k < 3; k++) begin
            instr_in = 16'h4200;
            step();
            instr_in = 16'h4441;
            ex_memread = 1'b1; ex_rd = 3'd2;
            step();
            ex_memread = 1'b0;
            step();
        end
        chk("cnt3", stall_count, 16'd3);
        instr_in = 16'h4200;
        step();
        ex_memread = 1'b1; ex_rd = 3'd2;
        repeat (65540) @(posedge clk);
        @(negedge clk);
        chk("cnt_sat", stall_count, 16'hFFFF);
        idle_inputs();
        mid_reset();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
